// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default widths, memory
// mode encodings, read-owner enum and the in-flight read tag.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 2;

  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grants, combinational in the request
// cycle, with a registered record of which port was granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_t last_q;

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = (last_q == OWN_D) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Reset marks the data port as last granted so fetch wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_D;
    end else if (gnt[0]) begin
      last_q <= OWN_IF;
    end else if (gnt[1]) begin
      last_q <= OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a
// data port; read responses are routed back via a tag shift register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_mode,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [1:0] req;
  logic [1:0] gnt;
  rd_tag_t    push;
  rd_tag_t    head;
  rd_tag_t    tag_q [RD_LAT];

  // Requests are masked in reset so no grant or memory access leaks out.
  assign req = {d_req, if_req} & {2{rst_n}};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    if_gnt     = gnt[0];
    d_gnt      = gnt[1];
    mem_addr   = '0;
    mem_mode   = MODE_READ;
    mem_datain = '0;
    if (gnt[0]) begin
      mem_addr = if_addr;
    end else if (gnt[1]) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_mode   = MODE_WRITE;
        mem_datain = d_wdata;
      end
    end
    push.valid = gnt[0] | (gnt[1] & ~d_we);
    push.owner = gnt[1] ? OWN_D : OWN_IF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= push;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    head      = tag_q[RD_LAT-1];
    if_rvalid = head.valid && (head.owner == OWN_IF);
    d_rvalid  = head.valid && (head.owner == OWN_D);
    if_rdata  = if_rvalid ? mem_data_out : '0;
    d_rdata   = d_rvalid ? mem_data_out : '0;
  end

endmodule
